cpu_seq_ctrl: RTL and testbench

Multi-cycle control sequencer for the 16-bit CPU core. It takes the opcode (instruction[3:0]) held in the instruction register, plus ALU branch flags and a memory ready handshake, and steps the shared datapath through fetch, decode, execute, memory and write-back. It drives every datapath enable and mux select, including PC, IR, register file, ALU and memory. It also keeps a retired-instruction counter.

---
 rtl/cpu_seq_ctrl_if.sv | 42 ++++
 rtl/cpu_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_seq_ctrl_if.sv
// ============================================================================
//  Module   : cpu_seq_ctrl_if
//  Brief    : Bundle between the control sequencer and the CPU datapath/memory.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_seq_ctrl_if #(
    parameter int INSTRET_W = 16
);
    logic [3:0]           ir_op;
    logic                 alu_zero;
    logic                 alu_le;
    logic                 mem_ready;
    logic                 ir_we;
    logic                 pc_we;
    logic [1:0]           pc_sel;
    logic                 rf_we;
    logic [1:0]           wb_sel;
    logic [2:0]           alu_op;
    logic                 alu_src_imm;
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_byte;
    logic                 addr_sel;
    logic                 halted;
    logic [INSTRET_W-1:0] instret;

    modport master (
        input  ir_op, alu_zero, alu_le, mem_ready,
        output ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_op, alu_src_imm,
               mem_req, mem_we, mem_byte, addr_sel, halted, instret
    );

    modport slave (
        output ir_op, alu_zero, alu_le, mem_ready,
        input  ir_we, pc_we, pc_sel, rf_we, wb_sel, alu_op, alu_src_imm,
               mem_req, mem_we, mem_byte, addr_sel, halted, instret
    );
endinterface

`default_nettype wire

// File: rtl/cpu_seq_ctrl.sv
// ============================================================================
//  Module   : cpu_seq_ctrl
//  Brief    : Multi-cycle fetch/decode/execute/memory/write-back sequencer
//             with retired-instruction counter for the 16-bit CPU core.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_seq_ctrl #(
    parameter int         INSTRET_W = 16,
    parameter logic [3:0] HALT_OP   = 4'b1111
) (
    input wire             clk,
    input wire             rst,
    cpu_seq_ctrl_if.master bus
);

    localparam logic [2:0] c_FETCH  = 3'd0;
    localparam logic [2:0] c_DECODE = 3'd1;
    localparam logic [2:0] c_EXEC   = 3'd2;
    localparam logic [2:0] c_MEM    = 3'd3;
    localparam logic [2:0] c_WB     = 3'd4;
    localparam logic [2:0] c_HALT   = 3'd5;

    localparam logic [3:0] c_OP_JAL  = 4'd0;
    localparam logic [3:0] c_OP_JALR = 4'd1;
    localparam logic [3:0] c_OP_BEQ  = 4'd2;
    localparam logic [3:0] c_OP_BLE  = 4'd3;
    localparam logic [3:0] c_OP_LB   = 4'd4;
    localparam logic [3:0] c_OP_LW   = 4'd5;
    localparam logic [3:0] c_OP_SB   = 4'd6;
    localparam logic [3:0] c_OP_SW   = 4'd7;
    localparam logic [3:0] c_OP_ADD  = 4'd8;
    localparam logic [3:0] c_OP_SUB  = 4'd9;
    localparam logic [3:0] c_OP_AND  = 4'd10;
    localparam logic [3:0] c_OP_OR   = 4'd11;
    localparam logic [3:0] c_OP_ADDI = 4'd12;
    localparam logic [3:0] c_OP_SUBI = 4'd13;
    localparam logic [3:0] c_OP_LUI  = 4'd14;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_SUB  = 3'd1;
    localparam logic [2:0] c_ALU_AND  = 3'd2;
    localparam logic [2:0] c_ALU_OR   = 3'd3;
    localparam logic [2:0] c_ALU_PASS = 3'd4;

    localparam logic [1:0] c_PC_PLUS2 = 2'd0;
    localparam logic [1:0] c_PC_IMM   = 2'd1;
    localparam logic [1:0] c_PC_ALU   = 2'd2;

    localparam logic [1:0] c_WB_ALU = 2'd0;
    localparam logic [1:0] c_WB_MEM = 2'd1;
    localparam logic [1:0] c_WB_PC2 = 2'd2;

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [INSTRET_W-1:0] r_instret;

    logic       w_retire;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_sel;
    logic       w_rf_we;
    logic [1:0] w_wb_sel;
    logic [2:0] w_alu_op;
    logic       w_alu_src_imm;
    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_mem_byte;
    logic       w_addr_sel;
    logic       w_halted;

    logic w_is_load;
    logic w_is_store;
    logic w_is_byte;
    logic w_writes_rf;
    logic w_taken;

    assign w_is_load   = (bus.ir_op == c_OP_LB) || (bus.ir_op == c_OP_LW);
    assign w_is_store  = (bus.ir_op == c_OP_SB) || (bus.ir_op == c_OP_SW);
    assign w_is_byte   = (bus.ir_op == c_OP_LB) || (bus.ir_op == c_OP_SB);
    // Undefined opcodes reach WB as no-ops, so only known writers may set rf_we there
    assign w_writes_rf = w_is_load || ((bus.ir_op >= c_OP_ADD) && (bus.ir_op <= c_OP_LUI));
    assign w_taken     = (bus.ir_op == c_OP_BEQ) ? bus.alu_zero : bus.alu_le;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_retire) begin
                r_instret <= r_instret + INSTRET_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_retire      = 1'b0;
        w_ir_we       = 1'b0;
        w_pc_we       = 1'b0;
        w_pc_sel      = c_PC_PLUS2;
        w_rf_we       = 1'b0;
        w_wb_sel      = c_WB_ALU;
        w_alu_op      = c_ALU_ADD;
        w_alu_src_imm = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_mem_byte    = 1'b0;
        w_addr_sel    = 1'b0;
        w_halted      = 1'b0;

        case (r_state)
            c_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_state_next = c_DECODE;
                end
            end

            c_DECODE: begin
                w_state_next = (bus.ir_op == HALT_OP) ? c_HALT : c_EXEC;
            end

            c_EXEC: begin
                case (bus.ir_op)
                    c_OP_JAL: begin
                        w_rf_we      = 1'b1;
                        w_wb_sel     = c_WB_PC2;
                        w_pc_we      = 1'b1;
                        w_pc_sel     = c_PC_IMM;
                        w_retire     = 1'b1;
                        w_state_next = c_FETCH;
                    end
                    c_OP_JALR: begin
                        w_alu_op      = c_ALU_ADD;
                        w_alu_src_imm = 1'b1;
                        w_rf_we       = 1'b1;
                        w_wb_sel      = c_WB_PC2;
                        w_pc_we       = 1'b1;
                        w_pc_sel      = c_PC_ALU;
                        w_retire      = 1'b1;
                        w_state_next  = c_FETCH;
                    end
                    c_OP_BEQ, c_OP_BLE: begin
                        w_alu_op     = c_ALU_SUB;
                        w_pc_we      = 1'b1;
                        w_pc_sel     = w_taken ? c_PC_IMM : c_PC_PLUS2;
                        w_retire     = 1'b1;
                        w_state_next = c_FETCH;
                    end
                    c_OP_LB, c_OP_LW, c_OP_SB, c_OP_SW: begin
                        w_alu_op      = c_ALU_ADD;
                        w_alu_src_imm = 1'b1;
                        w_state_next  = c_MEM;
                    end
                    c_OP_ADD, c_OP_ADDI: begin
                        w_alu_op      = c_ALU_ADD;
                        w_alu_src_imm = (bus.ir_op == c_OP_ADDI);
                        w_state_next  = c_WB;
                    end
                    c_OP_SUB, c_OP_SUBI: begin
                        w_alu_op      = c_ALU_SUB;
                        w_alu_src_imm = (bus.ir_op == c_OP_SUBI);
                        w_state_next  = c_WB;
                    end
                    c_OP_AND: begin
                        w_alu_op     = c_ALU_AND;
                        w_state_next = c_WB;
                    end
                    c_OP_OR: begin
                        w_alu_op     = c_ALU_OR;
                        w_state_next = c_WB;
                    end
                    c_OP_LUI: begin
                        w_alu_op      = c_ALU_PASS;
                        w_alu_src_imm = 1'b1;
                        w_state_next  = c_WB;
                    end
                    default: begin
                        w_state_next = c_WB;
                    end
                endcase
            end

            c_MEM: begin
                w_mem_req     = 1'b1;
                w_addr_sel    = 1'b1;
                w_alu_op      = c_ALU_ADD;
                w_alu_src_imm = 1'b1;
                w_mem_we      = w_is_store;
                w_mem_byte    = w_is_byte;
                if (bus.mem_ready) begin
                    if (w_is_store) begin
                        w_pc_we      = 1'b1;
                        w_pc_sel     = c_PC_PLUS2;
                        w_retire     = 1'b1;
                        w_state_next = c_FETCH;
                    end else begin
                        w_state_next = c_WB;
                    end
                end
            end

            c_WB: begin
                w_rf_we      = w_writes_rf;
                w_wb_sel     = w_is_load ? c_WB_MEM : c_WB_ALU;
                w_pc_we      = 1'b1;
                w_pc_sel     = c_PC_PLUS2;
                w_retire     = 1'b1;
                w_state_next = c_FETCH;
            end

            c_HALT: begin
                w_halted = 1'b1;
            end

            default: begin
                w_state_next = c_FETCH;
            end
        endcase

        // Reset silences every output at once, including a pending memory request
        if (rst) begin
            w_state_next  = c_FETCH;
            w_retire      = 1'b0;
            w_ir_we       = 1'b0;
            w_pc_we       = 1'b0;
            w_pc_sel      = c_PC_PLUS2;
            w_rf_we       = 1'b0;
            w_wb_sel      = c_WB_ALU;
            w_alu_op      = c_ALU_ADD;
            w_alu_src_imm = 1'b0;
            w_mem_req     = 1'b0;
            w_mem_we      = 1'b0;
            w_mem_byte    = 1'b0;
            w_addr_sel    = 1'b0;
            w_halted      = 1'b0;
        end
    end

    assign bus.ir_we       = w_ir_we;
    assign bus.pc_we       = w_pc_we;
    assign bus.pc_sel      = w_pc_sel;
    assign bus.rf_we       = w_rf_we;
    assign bus.wb_sel      = w_wb_sel;
    assign bus.alu_op      = w_alu_op;
    assign bus.alu_src_imm = w_alu_src_imm;
    assign bus.mem_req     = w_mem_req;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_byte    = w_mem_byte;
    assign bus.addr_sel    = w_addr_sel;
    assign bus.halted      = w_halted;
    assign bus.instret     = rst ? '0 : r_instret;

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq_ctrl.sv
// ============================================================================
//  Module   : tb_cpu_seq_ctrl
//  Brief    : Scoreboard bench for cpu_seq_ctrl; one record per instruction,
//             checked when the DUT retires it.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_seq_ctrl;

    localparam int c_IW = 2;

    typedef struct {
        logic [3:0] op;
        int         lat;
        int         pc_sel;
        int         rf_we;
        int         wb_sel;
        int         instret;
        int         alu_op;
        int         src_imm;
        int         mem_we;
        int         mem_byte;
        int         mem_cyc;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    cpu_seq_ctrl_if #(.INSTRET_W(c_IW)) bus ();

    cpu_seq_ctrl #(.INSTRET_W(c_IW), .HALT_OP(4'b1111)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_chk   = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   sw_cnt  = 0;
    exp_t sb[$];

    int   snap_alu;
    int   snap_imm;
    int   snap_we;
    int   snap_byte;
    int   mem_cyc;
    int   irwe_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int f_lat(input logic [3:0] op, input int mw);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return 3;
            4'd4, 4'd5:             return 5 + mw;
            4'd6, 4'd7:             return 4 + mw;
            default:                return 4;
        endcase
    endfunction

    function automatic int f_pc_sel(input logic [3:0] op, input logic z, input logic le);
        case (op)
            4'd0:    return 1;
            4'd1:    return 2;
            4'd2:    return int'(z);
            4'd3:    return int'(le);
            default: return 0;
        endcase
    endfunction

    function automatic int f_alu(input logic [3:0] op);
        case (op)
            4'd2, 4'd3, 4'd9, 4'd13: return 1;
            4'd10:                   return 2;
            4'd11:                   return 3;
            4'd14:                   return 4;
            default:                 return 0;
        endcase
    endfunction

    // Retire monitor: every pc_we must match the oldest outstanding record
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.pc_we) begin
            if (sb.size() == 0) begin
                chk("unexpected_retire", 1, 0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("latency op%0d", e.op),  cyc - e.start + 1, e.lat);
                chk($sformatf("pc_sel op%0d", e.op),   int'(bus.pc_sel), e.pc_sel);
                chk($sformatf("rf_we op%0d", e.op),    int'(bus.rf_we), e.rf_we);
                chk($sformatf("wb_sel op%0d", e.op),   int'(bus.wb_sel), e.wb_sel);
                chk($sformatf("instret op%0d", e.op),  int'(bus.instret), e.instret);
                chk($sformatf("exec_alu op%0d", e.op), snap_alu, e.alu_op);
                chk($sformatf("exec_imm op%0d", e.op), snap_imm, e.src_imm);
                chk($sformatf("mem_we op%0d", e.op),   snap_we, e.mem_we);
                chk($sformatf("mem_byte op%0d", e.op), snap_byte, e.mem_byte);
                chk($sformatf("mem_cyc op%0d", e.op),  mem_cyc, e.mem_cyc);
                chk($sformatf("ir_we_cnt op%0d", e.op), irwe_cnt, 1);
            end
        end
    end

    // Drives one cycle of inputs; memory answers after the requested wait count
    task automatic drive_cycle(input logic r, input logic [3:0] op, input logic z,
                               input logic le, inout int fl, inout int ml);
        @(posedge clk);
        #1;
        rst          = r;
        bus.ir_op    = op;
        bus.alu_zero = z;
        bus.alu_le   = le;
        #1;
        if (bus.mem_req) begin
            if (!bus.addr_sel) begin
                bus.mem_ready = (fl == 0);
                if (fl > 0) fl--;
            end else begin
                bus.mem_ready = (ml == 0);
                if (ml > 0) ml--;
            end
        end else begin
            bus.mem_ready = 1'b1;
        end
        #2;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input logic le,
                             input int fw, input int mw);
        exp_t e;
        int   fl, ml, idx;
        bit   done;
        e.op       = op;
        e.lat      = f_lat(op, mw) + fw;
        e.pc_sel   = f_pc_sel(op, z, le);
        e.rf_we    = (op inside {4'd0, 4'd1, 4'd4, 4'd5, [4'd8:4'd14]}) ? 1 : 0;
        e.wb_sel   = (op inside {4'd0, 4'd1}) ? 2 : ((op inside {4'd4, 4'd5}) ? 1 : 0);
        e.instret  = sw_cnt;
        e.alu_op   = f_alu(op);
        e.src_imm  = (op inside {4'd1, [4'd4:4'd7], [4'd12:4'd14]}) ? 1 : 0;
        e.mem_we   = (op inside {4'd6, 4'd7}) ? 1 : 0;
        e.mem_byte = (op inside {4'd4, 4'd6}) ? 1 : 0;
        e.mem_cyc  = (op inside {[4'd4:4'd7]}) ? mw + 1 : 0;
        e.start    = cyc + 1;
        sb.push_back(e);
        sw_cnt = (sw_cnt + 1) % (1 << c_IW);

        fl = fw; ml = mw; idx = 0; done = 0;
        snap_alu = 0; snap_imm = 0; snap_we = 0; snap_byte = 0; mem_cyc = 0; irwe_cnt = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            drive_cycle(1'b0, op, z, le, fl, ml);
            idx++;
            if (bus.ir_we) irwe_cnt++;
            if (idx == fw + 3) begin
                snap_alu = int'(bus.alu_op);
                snap_imm = int'(bus.alu_src_imm);
            end
            if (bus.mem_req && bus.addr_sel) begin
                mem_cyc++;
                snap_we   = snap_we | int'(bus.mem_we);
                snap_byte = snap_byte | int'(bus.mem_byte);
            end
            if (bus.pc_we) done = 1;
        end
        if (!done) begin
            chk($sformatf("timeout op%0d", op), 0, 1);
            sb.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic run_halt(input int fw);
        int fl, ml, early, hcnt, rcnt, irw;
        fl = fw; ml = 0; early = 0; hcnt = 0; rcnt = 0; irw = 0;
        for (int k = 1; k <= fw + 2 + 8; k++) begin
            drive_cycle(1'b0, 4'hF, 1'b0, 1'b0, fl, ml);
            if (bus.ir_we) irw++;
            if (k <= fw + 2) early = early | int'(bus.halted);
            else begin
                hcnt += int'(bus.halted);
                rcnt += int'(bus.mem_req);
            end
        end
        chk("halt_early", early, 0);
        chk("halt_hold", hcnt, 8);
        chk("halt_no_req", rcnt, 0);
        chk("halt_ir_we", irw, 1);
        chk("halt_instret", int'(bus.instret), sw_cnt);
    endtask

    task automatic apply_reset(input int n);
        int fl, ml;
        fl = 0; ml = 0;
        for (int k = 0; k < n; k++) begin
            drive_cycle(1'b1, bus.ir_op, 1'b1, 1'b1, fl, ml);
            bus.mem_ready = 1'b1;
            #1;
            chk("rst_outputs",
                int'({bus.ir_we, bus.pc_we, bus.pc_sel, bus.rf_we, bus.wb_sel, bus.alu_op,
                      bus.alu_src_imm, bus.mem_req, bus.mem_we, bus.mem_byte, bus.addr_sel,
                      bus.halted, bus.instret}), 0);
        end
        sw_cnt = 0;
    endtask

    task automatic fetch_reset();
        int fl, ml;
        fl = 10; ml = 0;
        for (int k = 0; k < 2; k++) begin
            drive_cycle(1'b0, 4'd8, 1'b0, 1'b0, fl, ml);
            chk("stall_req", int'(bus.mem_req), 1);
            chk("stall_ir_we", int'(bus.ir_we), 0);
        end
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        #2;
        chk("rst_drop_req", int'(bus.mem_req), 0);
        chk("rst_drop_ir_we", int'(bus.ir_we), 0);
        sw_cnt = 0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.ir_op     = 4'd0;
        bus.alu_zero  = 1'b0;
        bus.alu_le    = 1'b0;
        bus.mem_ready = 1'b0;

        apply_reset(2);
        repeat (3) run_instr(4'd8, 1'b0, 1'b0, 0, 0);
        run_instr(4'd5, 1'b0, 1'b0, 0, 3);
        run_instr(4'd2, 1'b1, 1'b0, 0, 0);
        run_instr(4'd2, 1'b0, 1'b1, 0, 0);
        run_instr(4'd3, 1'b0, 1'b1, 1, 0);
        run_instr(4'd3, 1'b1, 1'b0, 0, 0);
        run_instr(4'd1, 1'b0, 1'b0, 0, 0);
        run_instr(4'd0, 1'b0, 1'b0, 2, 0);
        run_instr(4'd6, 1'b0, 1'b0, 1, 2);
        run_instr(4'd4, 1'b0, 1'b0, 0, 1);
        for (int i = 0; i < 15; i++) begin
            run_instr(4'(i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        run_halt(1);
        apply_reset(1);
        run_instr(4'd9, 1'b0, 1'b0, 0, 0);
        run_instr(4'd7, 1'b0, 1'b0, 0, 0);
        fetch_reset();
        repeat (5) run_instr(4'd12, 1'b0, 1'b0, 0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
